display_fifo_rd_sequencer: RTL

//  Sequences readout of the display DMA FIFO into the HDMI timing stream. Sits between the VGA timing gen and the display FIFO/unpack path.

---
 rtl/display_pkg.sv | 25 ++
 rtl/display_sel_delay.sv | 36 +++
 rtl/display_fifo_rd_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the display FIFO read sequencer.
// Holds the FSM state encoding and the per-frame word-count arithmetic.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_WAIT_VS = 2'd2,
        ST_ACTIVE  = 2'd3
    } disp_rd_state_t;

    localparam int unsigned WORD_CNT_W = 21;

    // Number of FIFO words one complete frame should consume.
    function automatic int unsigned expected_words(
        input int unsigned crop_start,
        input int unsigned crop_end,
        input int unsigned lines
    );
        return (crop_end - crop_start) * lines;
    endfunction

    localparam int unsigned DEF_EXPECTED_WORDS = expected_words(210, 750, 1080);

endpackage

// File: rtl/display_sel_delay.sv
// LATENCY-deep 1-bit shift register that aligns the mux select with FIFO read data.
// Only reset clears it, so selects already in flight keep draining across state changes.
module display_sel_delay #(
    parameter int unsigned LATENCY = 3
) (
    input  logic clk,
    input  logic srst,
    input  logic sel_i,
    output logic sel_o
);

    logic [LATENCY-1:0] pipe_q;

    generate
        if (LATENCY == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (srst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= sel_i;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (srst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= {pipe_q[LATENCY-2:0], sel_i};
                end
            end
        end
    endgenerate

    assign sel_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/display_fifo_rd_sequencer.sv
// Gates display FIFO readout on fill level and vsync, issues reads inside the crop window,
// and tracks underflow / frame word-count errors with sticky debug status.
module display_fifo_rd_sequencer
    import display_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4096,
    parameter int unsigned START_LEVEL  = 2048,
    parameter int unsigned CROP_START   = 210,
    parameter int unsigned CROP_END     = 750,
    parameter int unsigned ACTIVE_LINES = 1080,
    parameter int unsigned RD_LATENCY   = 3
) (
    input  logic                          iHdmiClk,
    input  logic                          iRst,
    input  logic                          iEnable,
    input  logic                          iRstDebugReg,
    input  logic [$clog2(FIFO_DEPTH)-1:0] ivFifoCount,
    input  logic                          iFifoEmpty,
    input  logic                          iVgaVs,
    input  logic                          iVgaVd,
    input  logic [13:0]                   ivVgaX,
    output logic                          oFifoRdEn,
    output logic                          oDataSel,
    output logic [1:0]                    ov2State,
    output logic                          oUnderflowErr,
    output logic                          oFrameWordErr,
    output logic [31:0]                   ov32FrameCount
);

    localparam logic [WORD_CNT_W-1:0] EXPECTED_WORDS =
        WORD_CNT_W'(expected_words(CROP_START, CROP_END, ACTIVE_LINES));

    disp_rd_state_t         state_q, state_d;
    logic                   vs_q;
    logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [31:0]            frame_cnt_q, frame_cnt_d;
    logic                   underflow_q, underflow_d;
    logic                   frame_word_err_q, frame_word_err_d;

    logic                   vs_fall;
    logic                   in_window;
    logic                   fifo_above_start;
    logic                   rd_en;
    logic                   underflow_evt;
    logic                   frame_end;

    assign vs_fall          = vs_q && !iVgaVs;
    assign in_window        = iVgaVd && (32'(ivVgaX) >= CROP_START) && (32'(ivVgaX) < CROP_END);
    assign fifo_above_start = 32'(ivFifoCount) > START_LEVEL;
    // Reset gates the read strobe combinationally so reads stop in the reset cycle itself.
    assign rd_en            = !iRst && (state_q == ST_ACTIVE) && in_window;
    assign underflow_evt    = rd_en && iFifoEmpty;
    // Underflow wins over a coincident frame boundary: no compare, no frame count.
    assign frame_end        = (state_q == ST_ACTIVE) && vs_fall && !underflow_evt;

    always_comb begin
        state_d          = state_q;
        word_cnt_d       = word_cnt_q;
        frame_cnt_d      = frame_cnt_q;
        underflow_d      = underflow_q;
        frame_word_err_d = frame_word_err_q;

        case (state_q)
            ST_IDLE: begin
                if (iEnable) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (!iEnable)              state_d = ST_IDLE;
                else if (fifo_above_start) state_d = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                if (!iEnable)     state_d = ST_IDLE;
                else if (vs_fall) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (underflow_evt)            state_d = ST_FILL;
                else if (vs_fall && !iEnable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_ACTIVE) || underflow_evt || frame_end) begin
            word_cnt_d = '0;
        end else if (rd_en) begin
            word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
        end

        if (iRstDebugReg) begin
            underflow_d      = 1'b0;
            frame_word_err_d = 1'b0;
            frame_cnt_d      = '0;
        end else begin
            if (underflow_evt) underflow_d = 1'b1;
            if (frame_end) begin
                frame_cnt_d = frame_cnt_q + 32'd1;
                if (word_cnt_q != EXPECTED_WORDS) frame_word_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iHdmiClk) begin
        if (iRst) begin
            state_q          <= ST_IDLE;
            vs_q             <= 1'b1;
            word_cnt_q       <= '0;
            frame_cnt_q      <= '0;
            underflow_q      <= 1'b0;
            frame_word_err_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            vs_q             <= iVgaVs;
            word_cnt_q       <= word_cnt_d;
            frame_cnt_q      <= frame_cnt_d;
            underflow_q      <= underflow_d;
            frame_word_err_q <= frame_word_err_d;
        end
    end

    display_sel_delay #(
        .LATENCY (RD_LATENCY)
    ) u_sel_delay (
        .clk   (iHdmiClk),
        .srst  (iRst),
        .sel_i (rd_en),
        .sel_o (oDataSel)
    );

    assign oFifoRdEn      = rd_en;
    assign ov2State       = state_q;
    assign oUnderflowErr  = underflow_q;
    assign oFrameWordErr  = frame_word_err_q;
    assign ov32FrameCount = frame_cnt_q;

endmodule
